// File: rtl/tophat_model_loader_if.sv
// tophat_model_loader_if
//   Bundles the model-byte stream coming from the host I/O interface and
//   the node-memory write port going to the node RAM.
//   Stream side : model_byte_valid_i, model_byte_i, clear_i
//   Memory side : mem_we_o, mem_addr_o, mem_wdata_o
//   Stream bytes are plain one-cycle strobes with no backpressure: a byte is
//   taken on every rising edge where model_byte_valid_i is high, and the
//   loader never stalls the producer. mem_we_o is a one-cycle write strobe;
//   mem_addr_o/mem_wdata_o are valid whenever mem_we_o is high.
//   slave  : the loader (consumes the stream, drives the memory port)
//   master : the upstream/downstream environment
interface tophat_model_loader_if #(
    parameter int NODE_BYTES = 4,
    parameter int ADDR_W     = 5
);
    logic                    model_byte_valid_i;
    logic [7:0]              model_byte_i;
    logic                    clear_i;
    logic                    mem_we_o;
    logic [ADDR_W-1:0]       mem_addr_o;
    logic [8*NODE_BYTES-1:0] mem_wdata_o;

    modport slave (
        input  model_byte_valid_i, model_byte_i, clear_i,
        output mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output model_byte_valid_i, model_byte_i, clear_i,
        input  mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/tophat_model_loader.sv
// tophat_model_loader
//   Assembles the validated model byte stream into NODE_BYTES-wide tree-node
//   records and writes them to node memory. A download is framed as
//   header N, N*NODE_BYTES record bytes, then an XOR checksum byte covering
//   the header and all record bytes. model_valid_o gates the inference core.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     bus (slave)   : byte stream in, node-memory write port out
//     node_count_o  : header count of the current/last download
//     model_valid_o : complete model with good checksum is in memory
//     load_err_o    : last download rejected (bad header or checksum)
//     busy_o        : download in progress (loading records or checksum)
//     state_o       : current FSM state, for observation
module tophat_model_loader #(
    parameter int NODE_BYTES = 4,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    tophat_model_loader_if.slave bus,
    output logic [ADDR_W:0]   node_count_o,
    output logic              model_valid_o,
    output logic              load_err_o,
    output logic              busy_o,
    output logic [2:0]        state_o
);
    localparam int NCW  = ADDR_W + 1;
    localparam int BI_W = $clog2(NODE_BYTES);
    localparam int DW   = 8 * NODE_BYTES;
    localparam int CAP  = 1 << ADDR_W;

    localparam logic [2:0] S_HDR  = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CSUM = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
    logic [NCW-1:0]    node_idx_q, node_idx_d;
    logic [NCW-1:0]    node_count_q, node_count_d;
    logic [7:0]        csum_q, csum_d;
    logic [DW-1:0]     asm_q, asm_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic              model_valid_q, model_valid_d;
    logic              load_err_q, load_err_d;
    logic [DW-1:0]     asm_ins;
    logic              hdr_bad;

    // Assembly register with the incoming byte dropped into lane byte_idx.
    always_comb begin
        asm_ins = asm_q;
        for (int k = 0; k < NODE_BYTES; k++) begin
            if (byte_idx_q == BI_W'(k)) asm_ins[8*k +: 8] = bus.model_byte_i;
        end
    end

    // Compared in 32 bits so the bound holds for any ADDR_W.
    assign hdr_bad = (bus.model_byte_i == 8'd0) ||
                     ({24'd0, bus.model_byte_i} > 32'(CAP));

    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        node_idx_d    = node_idx_q;
        node_count_d  = node_count_q;
        csum_d        = csum_q;
        asm_d         = asm_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        model_valid_d = model_valid_q;
        load_err_d    = load_err_q;

        if (bus.clear_i) begin
            // Clear outranks a coincident byte; node_count and memory survive.
            state_d       = S_HDR;
            byte_idx_d    = '0;
            node_idx_d    = '0;
            csum_d        = '0;
            model_valid_d = 1'b0;
            load_err_d    = 1'b0;
        end else if (bus.model_byte_valid_i) begin
            case (state_q)
                S_HDR: begin
                    if (hdr_bad) begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end else begin
                        state_d      = S_LOAD;
                        node_count_d = NCW'(bus.model_byte_i);
                        byte_idx_d   = '0;
                        node_idx_d   = '0;
                        csum_d       = bus.model_byte_i;
                    end
                end
                S_LOAD: begin
                    asm_d  = asm_ins;
                    csum_d = csum_q ^ bus.model_byte_i;
                    if (byte_idx_q == BI_W'(NODE_BYTES - 1)) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = node_idx_q[ADDR_W-1:0];
                        mem_wdata_d = asm_ins;
                        byte_idx_d  = '0;
                        node_idx_d  = node_idx_q + NCW'(1);
                        // node_idx is one bit wider than the address, so
                        // N == 2^ADDR_W ends here rather than wrapping.
                        if (node_idx_q + NCW'(1) == node_count_q) state_d = S_CSUM;
                    end else begin
                        byte_idx_d = byte_idx_q + BI_W'(1);
                    end
                end
                S_CSUM: begin
                    if (bus.model_byte_i == csum_q) begin
                        state_d       = S_DONE;
                        model_valid_d = 1'b1;
                    end else begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end
                end
                default: ; // S_DONE / S_ERR: bytes ignored until clear
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_HDR;
            byte_idx_q    <= '0;
            node_idx_q    <= '0;
            node_count_q  <= '0;
            csum_q        <= '0;
            asm_q         <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            model_valid_q <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            node_idx_q    <= node_idx_d;
            node_count_q  <= node_count_d;
            csum_q        <= csum_d;
            asm_q         <= asm_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            model_valid_q <= model_valid_d;
            load_err_q    <= load_err_d;
        end
    end

    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign node_count_o    = node_count_q;
    assign model_valid_o   = model_valid_q;
    assign load_err_o      = load_err_q;
    assign busy_o          = (state_q == S_LOAD) || (state_q == S_CSUM);
    assign state_o         = state_q;
endmodule

// File: tb/tb_tophat_model_loader.sv
module tb_tophat_model_loader;
    localparam int NB = 4;
    localparam int AW = 5;
    localparam int W  = AW + 8 * NB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tophat_model_loader_if #(.NODE_BYTES(NB), .ADDR_W(AW)) bus ();

    logic [AW:0] node_count;
    logic        model_valid;
    logic        load_err;
    logic        busy;
    logic [2:0]  state;

    tophat_model_loader #(.NODE_BYTES(NB), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .node_count_o  (node_count),
        .model_valid_o (model_valid),
        .load_err_o    (load_err),
        .busy_o        (busy),
        .state_o       (state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   stim_q[$];

    // Scoreboard: every write strobe pops one expected {addr, data}.
    always @(negedge clk) begin
        if (bus.mem_we_o === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_write: observed %h expected no write",
                       {bus.mem_addr_o, bus.mem_wdata_o});
            end
            if (exp_q.size() != 0) begin
                logic [W-1:0] want;
                want = exp_q.pop_front();
                assert ({bus.mem_addr_o, bus.mem_wdata_o} === want) else begin
                    n_bad++;
                    $error("FAIL mem_write: observed %h expected %h",
                           {bus.mem_addr_o, bus.mem_wdata_o}, want);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called aligned to a falling edge; returns aligned to a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gmax);
        bus.model_byte_valid_i = 1'b1;
        bus.model_byte_i       = b;
        @(negedge clk);
        bus.model_byte_valid_i = 1'b0;
        repeat ($urandom_range(gmax)) @(negedge clk);
    endtask

    task automatic send_stream(input int gmax);
        while (stim_q.size() != 0) send_byte(stim_q.pop_front(), gmax);
    endtask

    task automatic do_clear();
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
    endtask

    task automatic nominal(input logic [7:0] csum, input int gmax);
        exp_q.push_back({5'd0, 32'h44332211});
        exp_q.push_back({5'd1, 32'h88776655});
        stim_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'h55, 8'h66, 8'h77, 8'h88, csum};
        send_stream(gmax);
    endtask

    initial begin
        logic [7:0]    cs;
        logic [7:0]    nb[NB];
        logic [8*NB-1:0] d;

        bus.model_byte_valid_i = 1'b0;
        bus.model_byte_i       = 8'h00;
        bus.clear_i            = 1'b0;

        // Reset values
        #1;
        check("rst_we",    64'(bus.mem_we_o), 64'd0);
        check("rst_addr",  64'(bus.mem_addr_o), 64'd0);
        check("rst_wdata", 64'(bus.mem_wdata_o), 64'd0);
        check("rst_flags", 64'({node_count, model_valid, load_err, busy}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Nominal download
        exp_q.push_back({5'd0, 32'h44332211});
        exp_q.push_back({5'd1, 32'h88776655});
        send_byte(8'h02, 0);
        check("nom_busy_after_hdr", 64'(busy), 64'd1);
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_stream(0);
        check("nom_busy_csum", 64'(busy), 64'd1);
        check("nom_valid_before", 64'(model_valid), 64'd0);
        send_byte(8'h8A, 0);
        check("nom_valid", 64'(model_valid), 64'd1);
        check("nom_err", 64'(load_err), 64'd0);
        check("nom_count", 64'(node_count), 64'd2);
        check("nom_busy_end", 64'(busy), 64'd0);
        check("nom_drained", 64'(exp_q.size()), 64'd0);

        // Lockout after done: no writes, flags hold
        stim_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_stream(0);
        repeat (2) @(negedge clk);
        check("lock_valid", 64'(model_valid), 64'd1);

        // Clear: flags drop, count holds
        do_clear();
        check("clr_flags", 64'({model_valid, load_err, busy}), 64'd0);
        check("clr_count_holds", 64'(node_count), 64'd2);

        // Bad checksum
        nominal(8'h8B, 0);
        check("bad_err", 64'(load_err), 64'd1);
        check("bad_valid", 64'(model_valid), 64'd0);
        check("bad_drained", 64'(exp_q.size()), 64'd0);

        // Header bounds
        do_clear();
        send_byte(8'h00, 0);
        check("hdr0_err", 64'(load_err), 64'd1);
        check("hdr0_busy", 64'(busy), 64'd0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        do_clear();
        send_byte(8'h21, 0);
        check("hdr21_err", 64'(load_err), 64'd1);
        check("hdr21_busy", 64'(busy), 64'd0);

        // Full capacity: 32 nodes
        do_clear();
        send_byte(8'h20, 0);
        cs = 8'h20;
        for (int n = 0; n < 32; n++) begin
            d = '0;
            for (int k = 0; k < NB; k++) begin
                nb[k] = 8'($urandom_range(255));
                d[8*k +: 8] = nb[k];
                cs = cs ^ nb[k];
            end
            exp_q.push_back({AW'(n), d});
            for (int k = 0; k < NB; k++) send_byte(nb[k], 0);
        end
        check("full_last_addr", 64'(bus.mem_addr_o), 64'd31);
        send_byte(cs, 0);
        check("full_valid", 64'(model_valid), 64'd1);
        check("full_count", 64'(node_count), 64'd32);
        check("full_drained", 64'(exp_q.size()), 64'd0);

        // Gapped stream
        do_clear();
        nominal(8'h8A, 3);
        check("gap_valid", 64'(model_valid), 64'd1);
        check("gap_err", 64'(load_err), 64'd0);
        check("gap_drained", 64'(exp_q.size()), 64'd0);

        // Clear after 5 data bytes: node 0 completes, partial node 1 does not
        do_clear();
        exp_q.push_back({5'd0, 32'h44332211});
        stim_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_stream(0);
        do_clear();
        check("midclr_busy", 64'(busy), 64'd0);
        check("midclr_drained", 64'(exp_q.size()), 64'd0);
        nominal(8'h8A, 0);
        check("midclr_valid", 64'(model_valid), 64'd1);

        // Clear coincident with the byte that would complete a node
        do_clear();
        stim_q = '{8'h02, 8'h11, 8'h22, 8'h33};
        send_stream(0);
        bus.clear_i            = 1'b1;
        bus.model_byte_valid_i = 1'b1;
        bus.model_byte_i       = 8'h44;
        @(negedge clk);
        bus.clear_i            = 1'b0;
        bus.model_byte_valid_i = 1'b0;
        @(negedge clk);
        check("coclr_busy", 64'(busy), 64'd0);
        nominal(8'h8A, 0);
        check("coclr_valid", 64'(model_valid), 64'd1);
        check("coclr_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset mid-node
        do_clear();
        stim_q = '{8'h02, 8'h11, 8'h22, 8'h33};
        send_stream(0);
        #2 rst = 1'b1;
        #1;
        check("arst_we",    64'(bus.mem_we_o), 64'd0);
        check("arst_addr",  64'(bus.mem_addr_o), 64'd0);
        check("arst_wdata", 64'(bus.mem_wdata_o), 64'd0);
        check("arst_flags", 64'({node_count, model_valid, load_err, busy}), 64'd0);
        check("arst_state", 64'(state), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nominal(8'h8A, 0);
        check("arst_valid", 64'(model_valid), 64'd1);
        check("arst_count", 64'(node_count), 64'd2);
        check("arst_drained", 64'(exp_q.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
